lsu_pipe: RTL and testbench
===========================

// Module: lsu_pipe
// PURPOSE
//  Parametrised load/store unit between the LSQ issue port and the data memory. Accepts one LS op per
//  cycle (valid/ready), resolves LSQ-forwarded loads without memory access, drives byte-enabled
//  memory requests, waits a variable number of cycles for load data, and queues results in a completion
//  FIFO with backpressure toward the complete stage. Adds LB/SB lane handling, misalign detect and flush.
// PARAMETERS
//  AW        32  address width
//  DW        32  data width (multiple of 8; lanes = DW/8)
//  TAG_W     6   ROB tag width carried issue -> completion
//  CQ_DEPTH  4   completion FIFO entries (power of 2, >=2)
// PORTS
//  clk              in   1        clock, all state on rising edge
//  rstn             in   1        asynchronous active-low reset
//  issue_valid_i    in   1        LSQ presents an op
//  issue_ready_o    out  1        = (state==IDLE) & !cq_full & !flush_i
//  issue_op_i       in   4        LB=7 LW=8 SB=9 SW=10; other codes dropped
//  issue_tag_i      in   TAG_W    ROB tag
//  issue_pc_i       in   32       instruction PC
//  issue_addr_i     in   AW       effective address
//  issue_sdata_i    in   DW       store data
//  issue_fwd_hit_i  in   1        load satisfied by LSQ forwarding
//  issue_fwd_data_i in   DW       forwarded load data (already lane-aligned by LSQ)
//  flush_i          in   1        pipeline flush
//  mem_req_o        out  1        one-cycle request strobe (registered)
//  mem_we_o         out  1        1 = store
//  mem_addr_o       out  AW       word-aligned address (addr[1:0]=0)
//  mem_wdata_o      out  DW       store data, byte replicated for SB
//  mem_be_o         out  DW/8     byte enables
//  mem_rvalid_i     in   1        load data valid
//  mem_rdata_i      in   DW       load word
//  cmp_valid_o      out  1        FIFO head valid
//  cmp_ready_i      in   1        complete stage takes head
//  cmp_tag_o/cmp_pc_o/cmp_data_o  out TAG_W/32/DW  head fields
//  cmp_is_store_o / cmp_from_lsq_o / cmp_misalign_o  out 1 each  head flags
// BEHAVIOUR
//  - Reset: all outputs 0, FIFO empty (ptrs 0), state IDLE, captured op regs 0.
//  - Accept = issue_valid_i & issue_ready_o; acceptance edge = end of cycle N.
//  - Non-LS op accepted and discarded: no mem_req, no completion.
//  - LW/SW with addr[1:0]!=0: no mem access; entry {misalign=1,data=0} pushed at edge N, visible N+1.
//  - Fwd-hit load: entry {data=fwd_data, from_lsq=1} pushed at edge N; cmp_valid from N+1; no mem_req.
//  - Store: mem_req/we=1 in N+1 only; SW be=all 1s; SB be=1<<addr[1:0], wdata={lanes{sdata[7:0]}};
//    entry {is_store=1,data=0} pushed at edge N; state stays IDLE (back-to-back stores each cycle).
//  - Load miss: mem_req=1,we=0,be=all 1s in N+1; state MEM_WAIT from N+1 (rvalid in N+1 legal).
//    rvalid in cycle M: LW data=rdata; LB data=sign-ext of byte lane addr[1:0]; push at edge M,
//    cmp_valid from M+1, state IDLE from M+1. Min load latency accept->cmp_valid = 2 cycles.
//  - mem_rvalid_i ignored in IDLE.
//  - FSM: IDLE->MEM_WAIT (load miss); MEM_WAIT->IDLE (rvalid & !flush); MEM_WAIT->DRAIN (flush & !rvalid);
//    MEM_WAIT->IDLE (flush & rvalid, data dropped); DRAIN->IDLE on rvalid (data dropped); flush in DRAIN held.
//  - FIFO: ptrs log2(CQ_DEPTH)+1 bits, wrap bit distinguishes full/empty; head stable while valid & !ready.
//    Full: issue_ready low; pop while full frees slot but push accepted earliest next cycle (no bypass).
//    Push and pop same cycle when neither full nor empty: count unchanged.
//  - flush_i: FIFO emptied at that edge (ptrs equal), any push that cycle suppressed, mem_req already
//    issued not retracted; cmp_valid low from next cycle.
//  - Reset asserted mid-load: state IDLE immediately; late rvalid after reset ignored.
// STRUCTURE
//  - lsu_pkg: op codes LB/LW/SB/SW, state enum {IDLE,MEM_WAIT,DRAIN}, completion-entry struct.
//  - Sub-module lsu_cmp_fifo (param WIDTH, DEPTH): sync FIFO with push/pop/flush, full/empty.
//  - Top: accept logic, FSM, lane/extend logic, registered mem request outputs.
// TESTING
//  - LW addr 0x100, miss, rvalid 3 cycles later rdata=0xDEADBEEF -> one mem_req, cmp data 0xDEADBEEF, tag kept.
//  - LB addr 0x103, rdata=0x80FF0000 -> be=4'hF, cmp_data=0xFFFFFF80; LB 0x101 same word -> 0x00000000.
//  - SB addr 0x202 sdata=0x12345678 -> be=4'b0100, wdata=0x78787878, cmp is_store=1; SW 0x201 -> misalign=1, no req.
//  - Fwd-hit LW data 0xCAFE0001 -> no mem_req, cmp_valid next cycle, from_lsq=1.
//  - cmp_ready=0, 5 stores -> 4 accepted, ready low on 5th; one pop -> 5th accepted the cycle after.
//  - Flush during MEM_WAIT, rvalid 2 cycles later -> DRAIN, data dropped, FIFO empty, IDLE after rvalid.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types for the load/store pipe: op codes, FSM states and completion-entry flags.
package lsu_pkg;

  typedef enum logic [3:0] {
    OP_LB = 4'd7,
    OP_LW = 4'd8,
    OP_SB = 4'd9,
    OP_SW = 4'd10
  } ls_op_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_WAIT = 2'd1,
    DRAIN    = 2'd2
  } lsu_state_e;

  typedef struct packed {
    logic is_store;
    logic from_lsq;
    logic misalign;
  } cmp_flags_t;

  localparam int unsigned FLAG_W = $bits(cmp_flags_t);

endpackage

// File: rtl/lsu_cmp_fifo.sv
// Completion FIFO: wrap-bit pointers, flush empties it, no push-through-pop bypass when full.
module lsu_cmp_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] rd_data_c,
  output logic             full_c,
  output logic             empty_c
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [CW-1:0]    wptr;
  logic [CW-1:0]    rptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty_c   = (wptr == rptr);
  assign full_c    = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
  assign do_push   = push & ~full_c & ~flush;
  assign do_pop    = pop & ~empty_c & ~flush;
  // Head reads as zero while empty so stale entries never leak onto the bus.
  assign rd_data_c = empty_c ? '0 : mem[rptr[PW-1:0]];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + CW'(1);
      if (do_pop)  rptr <= rptr + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[PW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/lsu_pipe.sv
// Load/store pipe: accepts LSQ ops, issues byte-enabled memory requests, waits for load
// data and queues completions toward the complete stage.
module lsu_pipe
  import lsu_pkg::*;
#(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned TAG_W    = 6,
  parameter int unsigned CQ_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               issue_valid_i,
  output logic               issue_ready_o,
  input  logic [3:0]         issue_op_i,
  input  logic [TAG_W-1:0]   issue_tag_i,
  input  logic [31:0]        issue_pc_i,
  input  logic [AW-1:0]      issue_addr_i,
  input  logic [DW-1:0]      issue_sdata_i,
  input  logic               issue_fwd_hit_i,
  input  logic [DW-1:0]      issue_fwd_data_i,
  input  logic               flush_i,
  output logic               mem_req_o,
  output logic               mem_we_o,
  output logic [AW-1:0]      mem_addr_o,
  output logic [DW-1:0]      mem_wdata_o,
  output logic [DW/8-1:0]    mem_be_o,
  input  logic               mem_rvalid_i,
  input  logic [DW-1:0]      mem_rdata_i,
  output logic               cmp_valid_o,
  input  logic               cmp_ready_i,
  output logic [TAG_W-1:0]   cmp_tag_o,
  output logic [31:0]        cmp_pc_o,
  output logic [DW-1:0]      cmp_data_o,
  output logic               cmp_is_store_o,
  output logic               cmp_from_lsq_o,
  output logic               cmp_misalign_o
);

  localparam int unsigned LANES = DW / 8;
  localparam int unsigned OFF_W = $clog2(LANES);
  localparam int unsigned EW    = FLAG_W + TAG_W + 32 + DW;

  lsu_state_e       state;
  logic [TAG_W-1:0] cap_tag;
  logic [31:0]      cap_pc;
  logic [OFF_W-1:0] cap_off;
  logic             cap_lb;

  logic             cq_full;
  logic             cq_empty;
  logic             cq_push;
  logic             cq_pop;
  logic [EW-1:0]    push_entry;
  logic [EW-1:0]    head_entry;
  cmp_flags_t       push_flags;
  cmp_flags_t       head_flags;
  logic [TAG_W-1:0] push_tag;
  logic [31:0]      push_pc;
  logic [DW-1:0]    push_data;

  logic             accept;
  logic             is_lb, is_lw, is_sb, is_sw, is_load, is_store;
  logic             misal;
  logic             store_go;
  logic             miss_go;
  logic             acc_push;
  logic             load_done;
  logic [OFF_W-1:0] off;
  logic [7:0]       rbyte;

  assign issue_ready_o = (state == IDLE) & ~cq_full & ~flush_i;
  assign accept        = issue_valid_i & issue_ready_o;
  assign off           = issue_addr_i[OFF_W-1:0];

  assign is_lb    = (issue_op_i == OP_LB);
  assign is_lw    = (issue_op_i == OP_LW);
  assign is_sb    = (issue_op_i == OP_SB);
  assign is_sw    = (issue_op_i == OP_SW);
  assign is_load  = is_lb | is_lw;
  assign is_store = is_sb | is_sw;
  assign misal    = (is_lw | is_sw) & (off != '0);

  // Misaligned, forwarded and store ops complete at acceptance; only load misses touch memory for data.
  assign store_go  = accept & is_store & ~misal;
  assign miss_go   = accept & is_load & ~misal & ~issue_fwd_hit_i;
  assign acc_push  = accept & (misal | is_store | (is_load & issue_fwd_hit_i));
  assign load_done = (state == MEM_WAIT) & mem_rvalid_i & ~flush_i;
  assign rbyte     = mem_rdata_i[{cap_off, 3'b000} +: 8];

  always_comb begin
    push_flags = '0;
    push_tag   = issue_tag_i;
    push_pc    = issue_pc_i;
    push_data  = '0;
    if (load_done) begin
      push_tag  = cap_tag;
      push_pc   = cap_pc;
      push_data = cap_lb ? {{(DW-8){rbyte[7]}}, rbyte} : mem_rdata_i;
    end else if (misal) begin
      push_flags.misalign = 1'b1;
    end else if (is_store) begin
      push_flags.is_store = 1'b1;
    end else begin
      push_flags.from_lsq = 1'b1;
      push_data           = issue_fwd_data_i;
    end
  end

  assign push_entry = {push_flags, push_tag, push_pc, push_data};
  assign cq_push    = ~flush_i & (acc_push | load_done);
  assign cq_pop     = cmp_ready_i & ~cq_empty;

  lsu_cmp_fifo #(
    .WIDTH (EW),
    .DEPTH (CQ_DEPTH)
  ) u_cq (
    .clk       (clk),
    .rstn      (rstn),
    .push      (cq_push),
    .wr_data   (push_entry),
    .pop       (cq_pop),
    .flush     (flush_i),
    .rd_data_c (head_entry),
    .full_c    (cq_full),
    .empty_c   (cq_empty)
  );

  assign cmp_valid_o = ~cq_empty;
  assign {head_flags, cmp_tag_o, cmp_pc_o, cmp_data_o} = head_entry;
  assign cmp_is_store_o = head_flags.is_store;
  assign cmp_from_lsq_o = head_flags.from_lsq;
  assign cmp_misalign_o = head_flags.misalign;

  // FSM, captured load context and the registered one-cycle memory request.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_be_o    <= '0;
      cap_tag     <= '0;
      cap_pc      <= '0;
      cap_off     <= '0;
      cap_lb      <= 1'b0;
    end else begin
      mem_req_o   <= store_go | miss_go;
      mem_we_o    <= store_go;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_be_o    <= '0;
      if (store_go | miss_go) begin
        mem_addr_o <= {issue_addr_i[AW-1:OFF_W], OFF_W'(0)};
        mem_be_o   <= '1;
        if (store_go) mem_wdata_o <= issue_sdata_i;
        if (store_go && is_sb) begin
          mem_be_o    <= LANES'(1) << off;
          mem_wdata_o <= {LANES{issue_sdata_i[7:0]}};
        end
      end
      if (miss_go) begin
        cap_tag <= issue_tag_i;
        cap_pc  <= issue_pc_i;
        cap_off <= off;
        cap_lb  <= is_lb;
      end
      case (state)
        IDLE:     if (miss_go) state <= MEM_WAIT;
        MEM_WAIT: begin
          if (mem_rvalid_i)  state <= IDLE;
          else if (flush_i)  state <= DRAIN;
        end
        DRAIN:    if (mem_rvalid_i) state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_pipe.sv
// Directed scenarios for lsu_pipe with a completion scoreboard (expected vs observed queues).
module tb_lsu_pipe;

  localparam logic [3:0] LB = 4'd7;
  localparam logic [3:0] LW = 4'd8;
  localparam logic [3:0] SB = 4'd9;
  localparam logic [3:0] SW = 4'd10;

  typedef struct packed {
    logic        is_store;
    logic        from_lsq;
    logic        misalign;
    logic [5:0]  tag;
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        issue_valid_i;
  logic        issue_ready_o;
  logic [3:0]  issue_op_i;
  logic [5:0]  issue_tag_i;
  logic [31:0] issue_pc_i;
  logic [31:0] issue_addr_i;
  logic [31:0] issue_sdata_i;
  logic        issue_fwd_hit_i;
  logic [31:0] issue_fwd_data_i;
  logic        flush_i;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        cmp_valid_o;
  logic        cmp_ready_i;
  logic [5:0]  cmp_tag_o;
  logic [31:0] cmp_pc_o;
  logic [31:0] cmp_data_o;
  logic        cmp_is_store_o;
  logic        cmp_from_lsq_o;
  logic        cmp_misalign_o;

  ent_t exp_q[$];
  ent_t obs_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   req_cnt = 0;
  int   rd = 0;

  lsu_pipe dut (
    .clk              (clk),
    .rstn             (rstn),
    .issue_valid_i    (issue_valid_i),
    .issue_ready_o    (issue_ready_o),
    .issue_op_i       (issue_op_i),
    .issue_tag_i      (issue_tag_i),
    .issue_pc_i       (issue_pc_i),
    .issue_addr_i     (issue_addr_i),
    .issue_sdata_i    (issue_sdata_i),
    .issue_fwd_hit_i  (issue_fwd_hit_i),
    .issue_fwd_data_i (issue_fwd_data_i),
    .flush_i          (flush_i),
    .mem_req_o        (mem_req_o),
    .mem_we_o         (mem_we_o),
    .mem_addr_o       (mem_addr_o),
    .mem_wdata_o      (mem_wdata_o),
    .mem_be_o         (mem_be_o),
    .mem_rvalid_i     (mem_rvalid_i),
    .mem_rdata_i      (mem_rdata_i),
    .cmp_valid_o      (cmp_valid_o),
    .cmp_ready_i      (cmp_ready_i),
    .cmp_tag_o        (cmp_tag_o),
    .cmp_pc_o         (cmp_pc_o),
    .cmp_data_o       (cmp_data_o),
    .cmp_is_store_o   (cmp_is_store_o),
    .cmp_from_lsq_o   (cmp_from_lsq_o),
    .cmp_misalign_o   (cmp_misalign_o)
  );

  always #5 clk = ~clk;

  function automatic ent_t mk(input logic st, input logic fl, input logic ma,
                              input logic [5:0] tag, input logic [31:0] pc, input logic [31:0] data);
    ent_t e;
    e.is_store = st;
    e.from_lsq = fl;
    e.misalign = ma;
    e.tag      = tag;
    e.pc       = pc;
    e.data     = data;
    return e;
  endfunction

  // Monitor: counts memory strobes and records every completion handed to the complete stage.
  always @(negedge clk) begin
    if (rstn && mem_req_o) req_cnt++;
    if (rstn && cmp_valid_o && cmp_ready_i)
      obs_q.push_back(mk(cmp_is_store_o, cmp_from_lsq_o, cmp_misalign_o, cmp_tag_o, cmp_pc_o, cmp_data_o));
  end

  task automatic drive(input logic [3:0] op, input logic [5:0] tag, input logic [31:0] pc,
                       input logic [31:0] addr, input logic [31:0] sdata,
                       input logic fwd, input logic [31:0] fdata);
    @(posedge clk); #1;
    issue_valid_i    = 1'b1;
    issue_op_i       = op;
    issue_tag_i      = tag;
    issue_pc_i       = pc;
    issue_addr_i     = addr;
    issue_sdata_i    = sdata;
    issue_fwd_hit_i  = fwd;
    issue_fwd_data_i = fdata;
    @(posedge clk); #1;
    issue_valid_i    = 1'b0;
    issue_fwd_hit_i  = 1'b0;
  endtask

  task automatic settle();
    for (int i = 0; i < 60 && obs_q.size() < exp_q.size(); i++) @(negedge clk);
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o} !== 70'd0) begin
      n_fail++; $display("FAIL reset_mem: got %h want 0", {mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o});
    end
    n_chk++;
    if ({cmp_valid_o, cmp_is_store_o, cmp_from_lsq_o, cmp_misalign_o, cmp_tag_o, cmp_pc_o, cmp_data_o} !== 74'd0) begin
      n_fail++; $display("FAIL reset_cmp: got %h want 0", {cmp_valid_o, cmp_tag_o, cmp_pc_o, cmp_data_o});
    end
    rstn = 1'b1;
    @(negedge clk);
    n_chk++;
    if (issue_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", issue_ready_o); end
    // Stray read data while idle must be ignored.
    @(posedge clk); #1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h5A5A5A5A;
    @(posedge clk); #1; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    settle();
    n_chk++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL idle_rvalid: got %0d entries want %0d", obs_q.size(), exp_q.size());
    end
  endtask

  task automatic test_lw_miss();
    int req0;
    req0 = req_cnt;
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 6'd5, 32'h1000, 32'hDEADBEEF));
    drive(LW, 6'd5, 32'h1000, 32'h100, 32'h0, 1'b0, 32'h0);
    n_chk++;
    if ({mem_req_o, mem_we_o, mem_addr_o, mem_be_o} !== {1'b1, 1'b0, 32'h100, 4'hF}) begin
      n_fail++; $display("FAIL lw_req: got %b %b %h %h want 1 0 00000100 f", mem_req_o, mem_we_o, mem_addr_o, mem_be_o);
    end
    n_chk++;
    if (issue_ready_o !== 1'b0) begin n_fail++; $display("FAIL lw_busy: ready %b want 0", issue_ready_o); end
    repeat (2) @(posedge clk);
    #1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEADBEEF;
    @(posedge clk); #1; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    settle();
    n_chk++;
    if (req_cnt - req0 != 1) begin n_fail++; $display("FAIL lw_reqcnt: got %0d want 1", req_cnt - req0); end
    n_chk++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL lw_count: got %0d entries want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = rd; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL lw_entry%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    rd = exp_q.size();
  endtask

  task automatic test_lb_lanes();
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 6'd7, 32'h1100, 32'hFFFFFF80));
    drive(LB, 6'd7, 32'h1100, 32'h103, 32'h0, 1'b0, 32'h0);
    n_chk++;
    if ({mem_req_o, mem_we_o, mem_addr_o, mem_be_o} !== {1'b1, 1'b0, 32'h100, 4'hF}) begin
      n_fail++; $display("FAIL lb_req: got %b %b %h %h want 1 0 00000100 f", mem_req_o, mem_we_o, mem_addr_o, mem_be_o);
    end
    // Data returned in the request cycle: fastest legal completion.
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h80FF0000;
    @(posedge clk); #1; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    n_chk++;
    if ({cmp_valid_o, cmp_data_o} !== {1'b1, 32'hFFFFFF80}) begin
      n_fail++; $display("FAIL lb_latency: got %b %h want 1 ffffff80", cmp_valid_o, cmp_data_o);
    end
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 6'd8, 32'h1104, 32'h00000000));
    drive(LB, 6'd8, 32'h1104, 32'h101, 32'h0, 1'b0, 32'h0);
    @(posedge clk); #1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h80FF0000;
    @(posedge clk); #1; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    settle();
    n_chk++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL lb_count: got %0d entries want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = rd; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL lb_entry%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    rd = exp_q.size();
  endtask

  task automatic test_store();
    int req0;
    req0 = req_cnt;
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 6'd9, 32'h2000, 32'h0));
    drive(SB, 6'd9, 32'h2000, 32'h202, 32'h12345678, 1'b0, 32'h0);
    n_chk++;
    if ({mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o} !== {1'b1, 1'b1, 32'h200, 4'b0100, 32'h78787878}) begin
      n_fail++; $display("FAIL sb_req: got %b %b %h %b %h want 1 1 00000200 0100 78787878",
                         mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o);
    end
    exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 6'd10, 32'h2004, 32'h0));
    drive(SW, 6'd10, 32'h2004, 32'h201, 32'hAAAA5555, 1'b0, 32'h0);
    n_chk++;
    if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL sw_misalign_req: got %b want 0", mem_req_o); end
    settle();
    n_chk++;
    if (req_cnt - req0 != 1) begin n_fail++; $display("FAIL store_reqcnt: got %0d want 1", req_cnt - req0); end
    n_chk++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL store_count: got %0d entries want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = rd; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL store_entry%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    rd = exp_q.size();
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    issue_valid_i = 1'b1; issue_op_i = SW; issue_fwd_hit_i = 1'b0;
    issue_tag_i = 6'd11; issue_pc_i = 32'h2100; issue_addr_i = 32'h300; issue_sdata_i = 32'h0BADF00D;
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 6'd11, 32'h2100, 32'h0));
    @(posedge clk); #1;
    n_chk++;
    if ({mem_req_o, mem_addr_o, mem_be_o, mem_wdata_o} !== {1'b1, 32'h300, 4'hF, 32'h0BADF00D}) begin
      n_fail++; $display("FAIL b2b_first: got %b %h %h %h", mem_req_o, mem_addr_o, mem_be_o, mem_wdata_o);
    end
    issue_tag_i = 6'd12; issue_pc_i = 32'h2104; issue_addr_i = 32'h304; issue_sdata_i = 32'hFEEDFACE;
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 6'd12, 32'h2104, 32'h0));
    @(posedge clk); #1;
    issue_valid_i = 1'b0;
    n_chk++;
    if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o} !== {1'b1, 1'b1, 32'h304, 32'hFEEDFACE}) begin
      n_fail++; $display("FAIL b2b_second: got %b %b %h %h", mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o);
    end
    settle();
    n_chk++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL b2b_count: got %0d entries want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = rd; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_entry%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    rd = exp_q.size();
  endtask

  task automatic test_fwd();
    int req0;
    req0 = req_cnt;
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 6'd3, 32'h3000, 32'hCAFE0001));
    drive(LW, 6'd3, 32'h3000, 32'h104, 32'h0, 1'b1, 32'hCAFE0001);
    n_chk++;
    if ({mem_req_o, cmp_valid_o, cmp_from_lsq_o, cmp_data_o} !== {1'b0, 1'b1, 1'b1, 32'hCAFE0001}) begin
      n_fail++; $display("FAIL fwd_head: got req=%b valid=%b lsq=%b data=%h want 0 1 1 cafe0001",
                         mem_req_o, cmp_valid_o, cmp_from_lsq_o, cmp_data_o);
    end
    drive(4'd3, 6'd4, 32'h3004, 32'h108, 32'h0, 1'b0, 32'h0);
    settle();
    n_chk++;
    if (req_cnt - req0 != 0) begin n_fail++; $display("FAIL fwd_reqcnt: got %0d want 0", req_cnt - req0); end
    n_chk++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL fwd_count: got %0d entries want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = rd; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL fwd_entry%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    rd = exp_q.size();
  endtask

  task automatic test_backpressure();
    int req0;
    req0 = req_cnt;
    cmp_ready_i = 1'b0;
    @(posedge clk); #1;
    issue_valid_i = 1'b1; issue_op_i = SW; issue_fwd_hit_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      issue_tag_i   = 6'(20 + k);
      issue_pc_i    = 32'h4000 + 32'(4 * k);
      issue_addr_i  = 32'h400 + 32'(4 * k);
      issue_sdata_i = 32'(k);
      if (k == 4) begin
        @(negedge clk);
        n_chk++;
        if (issue_ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_full: ready %b want 0", issue_ready_o); end
        @(posedge clk); #1; cmp_ready_i = 1'b1;
        @(negedge clk);
        n_chk++;
        if (issue_ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_no_bypass: ready %b want 0", issue_ready_o); end
        @(posedge clk); #1; cmp_ready_i = 1'b0;
      end
      @(negedge clk);
      n_chk++;
      if (issue_ready_o !== 1'b1) begin n_fail++; $display("FAIL bp_accept%0d: ready %b want 1", k, issue_ready_o); end
      exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 6'(20 + k), 32'h4000 + 32'(4 * k), 32'h0));
      @(posedge clk); #1;
    end
    issue_valid_i = 1'b0;
    cmp_ready_i   = 1'b1;
    settle();
    n_chk++;
    if (req_cnt - req0 != 5) begin n_fail++; $display("FAIL bp_reqcnt: got %0d want 5", req_cnt - req0); end
    n_chk++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL bp_count: got %0d entries want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = rd; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_entry%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    rd = exp_q.size();
  endtask

  task automatic test_flush();
    cmp_ready_i = 1'b0;
    drive(SW, 6'd30, 32'h5000, 32'h600, 32'h55, 1'b0, 32'h0);
    drive(LW, 6'd31, 32'h5004, 32'h500, 32'h0, 1'b0, 32'h0);
    n_chk++;
    if (cmp_valid_o !== 1'b1) begin n_fail++; $display("FAIL flush_pre: cmp_valid %b want 1", cmp_valid_o); end
    flush_i = 1'b1;
    @(posedge clk); #1; flush_i = 1'b0;
    n_chk++;
    if ({cmp_valid_o, issue_ready_o} !== 2'b00) begin
      n_fail++; $display("FAIL flush_drain: valid=%b ready=%b want 0 0", cmp_valid_o, issue_ready_o);
    end
    @(posedge clk); #1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h11112222;
    @(posedge clk); #1; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    n_chk++;
    if ({cmp_valid_o, issue_ready_o} !== 2'b01) begin
      n_fail++; $display("FAIL flush_idle: valid=%b ready=%b want 0 1", cmp_valid_o, issue_ready_o);
    end
    cmp_ready_i = 1'b1;
    settle();
    n_chk++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL flush_count: got %0d entries want %0d", obs_q.size(), exp_q.size());
    end
  endtask

  task automatic test_reset_mid_load();
    drive(LW, 6'd40, 32'h6000, 32'h700, 32'h0, 1'b0, 32'h0);
    rstn = 1'b0;
    #2;
    n_chk++;
    if ({issue_ready_o, mem_req_o} !== 2'b10) begin
      n_fail++; $display("FAIL rst_mid: ready=%b req=%b want 1 0", issue_ready_o, mem_req_o);
    end
    @(posedge clk); #1; rstn = 1'b1;
    @(posedge clk); #1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h77778888;
    @(posedge clk); #1; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    settle();
    n_chk++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL rst_late_rvalid: got %0d entries want %0d", obs_q.size(), exp_q.size());
    end
    n_chk++;
    if (issue_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_idle: ready %b want 1", issue_ready_o); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn             = 1'b0;
    issue_valid_i    = 1'b0;
    issue_op_i       = '0;
    issue_tag_i      = '0;
    issue_pc_i       = '0;
    issue_addr_i     = '0;
    issue_sdata_i    = '0;
    issue_fwd_hit_i  = 1'b0;
    issue_fwd_data_i = '0;
    flush_i          = 1'b0;
    mem_rvalid_i     = 1'b0;
    mem_rdata_i      = '0;
    cmp_ready_i      = 1'b1;
    test_reset();
    test_lw_miss();
    test_lb_lanes();
    test_store();
    test_back_to_back();
    test_fwd();
    test_backpressure();
    test_flush();
    test_reset_mid_load();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
